// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: generates the next program-counter address and
// drives a single-outstanding instruction-memory request with a valid/ready
// handshake. Redirects arriving while a request is waiting are held pending
// and applied when the handshake completes.
//
// state | meaning
// IDLE  | post-reset bubble, no request
// REQ   | request phase; imem_req held until imem_ready
// HOLD  | pipeline stalled, no request, redirects still captured
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          STEP         = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] NextPC,
  output logic [31:0] Address,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  localparam logic [31:0] STEP_INC = 32'(STEP);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        req_nxt;
  logic        handshake;
  logic        pend_valid;
  logic        pend_jump;
  logic [31:0] pend_target;
  logic        redir_valid;
  logic [31:0] redir_target;

  // NextPC only moves when Address moves, i.e. on handshake, so the request
  // address is stable for the whole time imem_req is high.
  assign imem_addr = NextPC;
  assign handshake = (state == REQ) && imem_req && imem_ready;

  // Redirect selection: jumps beat branches; a current request beats a
  // pending one of the same kind because it is the newer one.
  always_comb begin
    redir_valid  = 1'b0;
    redir_target = NextPC;
    if (jump) begin
      redir_valid  = 1'b1;
      redir_target = jump_target;
    end else if (pend_valid && pend_jump) begin
      redir_valid  = 1'b1;
      redir_target = pend_target;
    end else if (branch_taken) begin
      redir_valid  = 1'b1;
      redir_target = branch_target;
    end else if (pend_valid) begin
      redir_valid  = 1'b1;
      redir_target = pend_target;
    end
  end

  // State and request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      imem_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      imem_req <= req_nxt;
    end
  end

  // Next-state and next-request decode. A raised request is never dropped
  // before the handshake, whatever stall or redirects do.
  always_comb begin
    state_nxt = state;
    req_nxt   = imem_req;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        req_nxt   = !stall;
      end
      REQ: begin
        if (!imem_req) begin
          if (stall) begin
            state_nxt = HOLD;
            req_nxt   = 1'b0;
          end else begin
            req_nxt = 1'b1;
          end
        end else if (imem_ready) begin
          if (stall) begin
            state_nxt = HOLD;
            req_nxt   = 1'b0;
          end else begin
            req_nxt = 1'b1;
          end
        end else begin
          req_nxt = 1'b1;
        end
      end
      HOLD: begin
        req_nxt = 1'b0;
        if (!stall) begin
          state_nxt = REQ;
          req_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  // Pending redirect: captured whenever no handshake consumes it this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid  <= 1'b0;
      pend_jump   <= 1'b0;
      pend_target <= '0;
    end else if (handshake) begin
      pend_valid <= 1'b0;
      pend_jump  <= 1'b0;
    end else if (jump) begin
      pend_valid  <= 1'b1;
      pend_jump   <= 1'b1;
      pend_target <= jump_target;
    end else if (branch_taken) begin
      pend_valid  <= 1'b1;
      pend_jump   <= 1'b0;
      pend_target <= branch_target;
    end
  end

  // Address advances only on handshake; redirect targets are word-aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      Address <= RESET_VECTOR;
    end else if (handshake) begin
      if (redir_valid) Address <= {redir_target[31:2], 2'b00};
      else             Address <= NextPC + STEP_INC;
    end
  end

  // Completed-handshake counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset)          fetch_count <= '0;
    else if (handshake) fetch_count <= fetch_count + 32'd1;
  end

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                                              misalign_err <= 1'b0;
    else if (handshake && redir_valid && |redir_target[1:0]) misalign_err <= 1'b1;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. NextPC mirrors Address like a PC
// register would; each expected handshake is queued with its request address,
// resulting Address and fetch_count, and checked when the DUT completes it.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] NextPC;
  logic [31:0] Address;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] fetch_count;
  logic        misalign_err;

  typedef struct {
    logic [31:0] req;
    logic [31:0] nxt;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .NextPC        (NextPC),
    .Address       (Address),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .fetch_count   (fetch_count),
    .misalign_err  (misalign_err)
  );

  assign NextPC = Address;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] req, input logic [31:0] nxt, input logic [31:0] cnt);
    exp_t e;
    e.req = req;
    e.nxt = nxt;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  // One clock: score a handshake seen before the edge, then sample #1 after.
  task automatic tick();
    exp_t e;
    bit   have;
    have = 1'b0;
    if (!reset && imem_req && imem_ready) begin
      chk("hs_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e    = sb.pop_front();
        have = 1'b1;
        chk("hs_imem_addr", imem_addr, e.req);
      end
    end
    @(posedge clk);
    #1;
    if (have) begin
      chk("hs_address", Address, e.nxt);
      chk("hs_count", fetch_count, e.cnt);
    end
  endtask

  initial begin
    reset = 1'b1; branch_taken = 1'b0; branch_target = '0; jump = 1'b0;
    jump_target = '0; stall = 1'b0; imem_ready = 1'b0;
    tick(); tick();
    chk("rst_address", Address, 32'h0);
    chk("rst_req", imem_req, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_misalign", misalign_err, 32'd0);

    // Sequential fetch with a single IDLE bubble.
    reset = 1'b0; imem_ready = 1'b1;
    tick();
    chk("bubble_address", Address, 32'h0);
    chk("first_req", imem_req, 32'd1);
    push(32'h0, 32'h4, 1); push(32'h4, 32'h8, 2);
    push(32'h8, 32'hC, 3); push(32'hC, 32'h10, 4);
    repeat (4) tick();
    chk("seq_count", fetch_count, 32'd4);

    // Wait states at NextPC=8.
    reset = 1'b1; tick();
    reset = 1'b0; tick();
    push(32'h0, 32'h4, 1); push(32'h4, 32'h8, 2);
    tick(); tick();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req", imem_req, 32'd1);
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_address", Address, 32'h8);
      chk("wait_count", fetch_count, 32'd2);
    end
    push(32'h8, 32'hC, 3);
    imem_ready = 1'b1; tick();

    // Pending branch overwritten by a later jump.
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("pend_no_branch", Address, 32'hC);
    jump = 1'b1; jump_target = 32'h200;
    tick();
    jump = 1'b0;
    chk("pend_hold_addr", Address, 32'hC);
    push(32'hC, 32'h200, 4);
    imem_ready = 1'b1; tick();

    // Jump to the top of memory, then stalled handshake that wraps to 0.
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    push(32'h200, 32'hFFFF_FFFC, 5);
    tick();
    jump = 1'b0; stall = 1'b1;
    push(32'hFFFF_FFFC, 32'h0, 6);
    tick();
    chk("hold_req", imem_req, 32'd0);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    chk("hold_req2", imem_req, 32'd0);
    chk("hold_address", Address, 32'h0);
    chk("hold_count", fetch_count, 32'd6);
    tick();
    chk("hold_req3", imem_req, 32'd0);
    stall = 1'b0;
    tick();
    chk("resume_req", imem_req, 32'd1);
    chk("resume_addr", imem_addr, 32'h0);
    push(32'h0, 32'h40, 7);
    imem_ready = 1'b1; tick();
    chk("no_misalign_yet", misalign_err, 32'd0);

    // Misaligned jump target.
    jump = 1'b1; jump_target = 32'h103;
    push(32'h40, 32'h100, 8);
    tick();
    jump = 1'b0;
    chk("misalign_set", misalign_err, 32'd1);
    imem_ready = 1'b0;
    tick();
    chk("misalign_sticky", misalign_err, 32'd1);
    chk("misalign_address", Address, 32'h100);

    // Latch a pending jump, then reset mid-handshake.
    jump = 1'b1; jump_target = 32'h300;
    tick();
    jump = 1'b0; reset = 1'b1; imem_ready = 1'b1;
    tick();
    chk("midrst_address", Address, 32'h0);
    chk("midrst_req", imem_req, 32'd0);
    chk("midrst_count", fetch_count, 32'd0);
    chk("midrst_misalign", misalign_err, 32'd0);

    // Stall before the first request is issued, then pending-cleared check.
    reset = 1'b0; stall = 1'b1; imem_ready = 1'b0;
    tick();
    chk("prereq_req", imem_req, 32'd0);
    tick();
    chk("prereq_hold_req", imem_req, 32'd0);
    stall = 1'b0;
    tick();
    chk("prereq_resume", imem_req, 32'd1);
    push(32'h0, 32'h4, 1);
    imem_ready = 1'b1;
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the address loaded on reset.
REQ-002 The module SHALL have parameter STEP, default 4, the sequential address increment in bytes.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-005 Port NextPC, input, 32, current value driven by the program counter register.
REQ-006 Port Address, output, 32, registered next address to be loaded into the program counter.
REQ-007 Port branch_taken, input, 1, conditional redirect request.
REQ-008 Port branch_target, input, 32, redirect address for branch_taken.
REQ-009 Port jump, input, 1, unconditional redirect request.
REQ-010 Port jump_target, input, 32, redirect address for jump.
REQ-011 Port stall, input, 1, pipeline hold request.
REQ-012 Port imem_req, output, 1, registered instruction-memory request valid.
REQ-013 Port imem_addr, output, 32, request address, equal to NextPC whenever imem_req=1.
REQ-014 Port imem_ready, input, 1, memory accepts the request; handshake completes when imem_req=1 and imem_ready=1 in the same cycle.
REQ-015 Port fetch_count, output, 32, number of completed handshakes, modulo 2^32.
REQ-016 Port misalign_err, output, 1, sticky flag for a redirect target with bits [1:0] not equal to 0.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ, HOLD.
REQ-018 IDLE behaviour:
- imem_req=0.
- Next cycle unconditionally goes to REQ, giving one bubble after reset.
REQ-019 REQ behaviour: imem_req=1 and imem_addr=NextPC.
REQ-020 Once imem_req=1 in REQ, imem_req and imem_addr SHALL stay stable until the handshake completes, regardless of stall or redirect inputs.
REQ-021 On handshake completion in REQ:
- Address updates the next cycle.
- fetch_count increments by 1.
REQ-022 Address update priority: pending/current jump, then pending/current branch, then NextPC+STEP.
REQ-023 A redirect asserted while no handshake completes in that cycle SHALL be latched as a pending redirect (target plus valid bit).
REQ-024 A later redirect SHALL overwrite the pending one, and jump SHALL override branch in the same cycle.
REQ-025 Applying the pending redirect SHALL clear it in the same cycle.
REQ-026 Sequential increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 gives 32'h0000_0000) with no error.
REQ-027 Redirect target bits [1:0] SHALL be forced to 0 in Address, and misalign_err SHALL be set, remaining 1 until reset.
REQ-028 Stall sampled high at handshake completion SHALL move the FSM to HOLD.
REQ-029 Stall sampled high in REQ before imem_req is first asserted SHALL move the FSM to HOLD with no request issued.
REQ-030 HOLD behaviour:
- imem_req=0, Address held, fetch_count held.
- Redirects are still latched as pending.
- Returns to REQ the cycle after stall is low.
REQ-031 Simultaneous stall and redirect at handshake completion SHALL apply the redirect to Address and enter HOLD.
REQ-032 Address SHALL change only on handshake completion or reset.

Reset
REQ-033 While reset=1 the module SHALL drive:
- Address=RESET_VECTOR
- imem_req=0
- fetch_count=0
- misalign_err=0
- pending redirect cleared
- state=IDLE
REQ-034 Reset asserted mid-handshake SHALL abandon the outstanding request with no fetch_count increment.
REQ-035 Reset SHALL override every other input in the same cycle.

Verification
REQ-036 Sequential fetch: reset; NextPC follows Address; imem_ready=1 always -> Address 0,4,8,12,16 on consecutive cycles after the IDLE bubble; fetch_count=4 after four handshakes.
REQ-037 Wait states: imem_ready=0 for 3 cycles with NextPC=8 -> imem_req=1, imem_addr=8 stable for 3 cycles; Address=12 and fetch_count increments only after imem_ready=1.
REQ-038 Pending redirect: branch_taken=1, branch_target=0x100 during a wait, then jump=1, jump_target=0x200 in a later wait cycle -> Address=0x200 after completion; 0x100 never appears.
REQ-039 Stall and wrap:
- Stall at NextPC=0xFFFFFFFC handshake -> Address=0, imem_req=0 while stall=1.
- Request resumes one cycle after stall drops.
REQ-040 Misalign and reset: jump_target=0x103 -> Address=0x100 and misalign_err=1 stays set; mid-wait reset -> all outputs at reset values and misalign_err=0.
